// File: rtl/bcd_seg7_scanner_pkg.sv
// Shared constants for the 3-digit BCD 7-segment scanner: active-high segment
// patterns (bit0=a .. bit6=g) and the digit-slot encoding.
package bcd_seg7_scanner_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2
    } digit_e;

endpackage

// File: rtl/bcd_seg7_scanner_if.sv
// Value-in / display-out bundle between the BCD source and the scanner.
interface bcd_seg7_scanner_if;
    logic [11:0]                                bcd;
    logic                                       bcd_valid;
    logic                                       blank_lz;
    logic [6:0]                                 seg;
    logic [bcd_seg7_scanner_pkg::NUM_DIGITS-1:0] an;
    logic                                       frame_done;

    modport master (
        output bcd, bcd_valid, blank_lz,
        input  seg, an, frame_done
    );

    modport slave (
        input  bcd, bcd_valid, blank_lz,
        output seg, an, frame_done
    );
endinterface

// File: rtl/bcd_seg7_scanner_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern; A-F show a dash.
module bcd_to_seg7
    import bcd_seg7_scanner_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    always_comb begin
        pat = SEG_DASH;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 3-digit 7-segment driver with shadowed, frame-aligned
// updates, leading-zero blanking and selectable output polarity.
module bcd_seg7_scanner
    import bcd_seg7_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_seg7_scanner_if.slave bus
);

    localparam int             PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic           POL       = (ACTIVE_LOW != 0);

    logic [PW-1:0]                  presc;
    digit_e                         idx;
    logic                           tick;
    logic                           boundary;
    logic [11:0]                    pending;
    logic [11:0]                    display;
    logic [NUM_DIGITS-1:0][6:0]     pat;
    logic [NUM_DIGITS-1:0]          blank;
    logic [6:0]                     seg_nx, seg_q;
    logic [NUM_DIGITS-1:0]          an_nx, an_q;
    logic                           fd_q;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (idx == DIG_HUNDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= DIG_ONES;
        end else if (tick) begin
            case (idx)
                DIG_ONES: idx <= DIG_TENS;
                DIG_TENS: idx <= DIG_HUNDS;
                default:  idx <= DIG_ONES;
            endcase
        end
    end

    // A strobe landing on the boundary bypasses pending so it is not a frame late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            display <= '0;
            fd_q    <= 1'b0;
        end else begin
            if (bus.bcd_valid) pending <= bus.bcd;
            if (boundary)      display <= bus.bcd_valid ? bus.bcd : pending;
            fd_q <= boundary;
        end
    end

    bcd_to_seg7 u_dec [NUM_DIGITS-1:0] (
        .nib (display),
        .pat (pat)
    );

    // blank_lz is deliberately live so the switch takes effect mid-frame.
    assign blank = {bus.blank_lz && (display[11:8] == 4'h0),
                    bus.blank_lz && (display[11:4] == 8'h00),
                    1'b0};

    always_comb begin
        seg_nx = SEG_OFF;
        an_nx  = '0;
        case (idx)
            DIG_ONES: begin
                seg_nx = pat[0];
                an_nx  = 3'b001;
            end
            DIG_TENS: if (!blank[1]) begin
                seg_nx = pat[1];
                an_nx  = 3'b010;
            end
            DIG_HUNDS: if (!blank[2]) begin
                seg_nx = pat[2];
                an_nx  = 3'b100;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {7{POL}};
            an_q  <= {NUM_DIGITS{POL}};
        end else begin
            seg_q <= seg_nx ^ {7{POL}};
            an_q  <= an_nx ^ {NUM_DIGITS{POL}};
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Randomized bench for bcd_seg7_scanner against a cycle-count reference model.
module tb_bcd_seg7_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 3 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bcd_seg7_scanner_if bus ();

    bcd_seg7_scanner #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] dec_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int          checks = 0;
    int          fails  = 0;
    int          k      = 0;   // clock edges since reset release
    logic [11:0] m_pend = '0;
    logic [11:0] m_disp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", tag, got, exp, k, $time);
        end
    endtask

    // Expected pins (active-low) for a displayed value, a slot and the blanking mode.
    function automatic void exp_out(input logic [11:0] d, input int slot, input logic blz,
                                    output logic [6:0] s, output logic [2:0] a);
        int  digit;
        bit  blanked;
        digit   = (d >> (4 * slot)) & 'hF;
        blanked = blz && ((slot == 2 && d[11:8] == 0) || (slot == 1 && d[11:4] == 0));
        if (blanked) begin
            s = 7'h00;
            a = 3'b000;
        end else begin
            s = (digit < 10) ? dec_tbl[digit] : 7'h40;
            a = 3'(1 << slot);
        end
        s = ~s;
        a = ~a;
    endfunction

    task automatic step();
        logic [6:0] es;
        logic [2:0] ea;
        logic       efd;
        exp_out(m_disp, (k / DIV) % 3, bus.blank_lz, es, ea);
        efd = ((k % FRAME) == FRAME - 1);
        if (efd)           m_disp = bus.bcd_valid ? bus.bcd : m_pend;
        if (bus.bcd_valid) m_pend = bus.bcd;
        @(posedge clk);
        #1;
        chk("seg", 32'(bus.seg), 32'(es));
        chk("an", 32'(bus.an), 32'(ea));
        chk("frame_done", 32'(bus.frame_done), 32'(efd));
        k++;
        bus.bcd_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_phase(input int r);
        int n = 0;
        while ((k % FRAME) != r && n < 2 * FRAME) begin
            step();
            n++;
        end
    endtask

    task automatic strobe(input logic [11:0] v);
        bus.bcd       = v;
        bus.bcd_valid = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_an", 32'(bus.an), 32'h7);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        k      = 0;
        m_pend = '0;
        m_disp = '0;
    endtask

    function automatic logic [3:0] rnd_nib();
        int r = $urandom_range(0, 9);
        if (r < 3)      return 4'd0;
        else if (r < 9) return 4'($urandom_range(1, 9));
        else            return 4'($urandom_range(10, 15));
    endfunction

    initial begin
        bus.bcd       = '0;
        bus.bcd_valid = 1'b0;
        bus.blank_lz  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        run(2 * FRAME + 2);

        strobe(12'h255);
        run(3 * FRAME);

        bus.blank_lz = 1'b1;
        strobe(12'h004);
        run(2 * FRAME + 2);
        bus.blank_lz = 1'b0;
        run(FRAME);

        strobe(12'h255);
        run(2 * FRAME);
        goto_phase(DIV + 1);
        strobe(12'h196);
        run(2 * FRAME);

        strobe(12'h0A0);
        run(2 * FRAME);
        goto_phase(FRAME - 1);
        strobe(12'h321);
        run(FRAME + 2);

        strobe(12'h255);
        run(2 * FRAME);
        goto_phase(DIV + 2);
        strobe(12'h196);
        do_reset();
        run(2 * FRAME);
        bus.blank_lz = 1'b1;
        run(FRAME + 1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) begin
                bus.bcd       = {rnd_nib(), rnd_nib(), rnd_nib()};
                bus.bcd_valid = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
Downstream consumer of the binary-to-BCD converter in the 4x4 multiplier display path. Takes the 12-bit, 3-digit BCD product, holds it in a shadow register, and time-multiplexes it onto a 3-digit common-anode 7-segment display. Provides refresh prescaling, tear-free update at frame boundaries, leading-zero blanking and an invalid-digit indication.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (>=2); 4 in simulation
ACTIVE_LOW, 1, 1 = seg/an active-low (common anode); 0 = active-high

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bcd  input  12  BCD value; [3:0] ones, [7:4] tens, [11:8] hundreds
bcd_valid  input  1  single-cycle strobe; capture bcd this edge
blank_lz  input  1  1 = blank leading zeros
seg  output  7  segments, bit0=a .. bit6=g
an  output  3  digit enables, bit0=ones, bit2=hundreds
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync-released by the system): prescaler=0, digit index=0, pending=0, display=0, frame_done=0; seg and an all inactive (ACTIVE_LOW=1: seg=7'h7F, an=3'b111).
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick is high in the cycle where count==REFRESH_DIV-1.
- Digit index: 0 -> 1 -> 2 -> 0, advancing on tick. A frame boundary is a tick with index==2.
- Capture: bcd_valid loads pending <= bcd. Multiple strobes in one frame: last one wins.
- Commit: on a frame boundary, display <= pending. If bcd_valid coincides with the boundary, display takes the bcd from that cycle (bypass).
- Updates mid-frame never change the current frame. This avoids tearing.
- frame_done: registered. High for exactly the one cycle after the boundary edge.
- Output stage: seg and an are registered from the current index and display value, so they have 1-cycle latency after an index change. Exactly one an is asserted per slot unless that digit is blanked.
- Decode:
  - Nibble 0-9: standard pattern. Active-high 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Nibble A-F: dash (g only, active-high 7'h40).
  - When ACTIVE_LOW=1, seg and an are the bitwise inverse.
- Leading-zero blanking (blank_lz=1):
  - Hundreds is blanked if its nibble ==0.
  - Tens is blanked if hundreds==0 and tens==0.
  - Ones is never blanked.
  - A blanked slot drives an all inactive and seg all off for the whole slot.
  - blank_lz is sampled live, not shadowed.
- Reset mid-operation: outputs go inactive immediately (asynchronously). All counters and registers clear. After release, the display shows 0 ("000", or ones-only "0" when blank_lz=1).
- No arithmetic beyond the counters. Prescaler width is clog2(REFRESH_DIV); index is 2 bits and never reaches 3.

Decomposition:
- Shared package / include: 7-segment pattern constants (digits 0-9, DASH, OFF), NUM_DIGITS=3.
- One natural sub-module: bcd_to_seg7. It is combinational: 4-bit nibble in, 7-bit active-high pattern out, with dash for A-F. The top applies polarity.
- The top holds the prescaler, index, shadow registers, blanking logic and output registers.

Test Plan:
All scenarios use REFRESH_DIV=4, ACTIVE_LOW=1.
1. Reset: rst_n=0 -> seg=7'h7F, an=3'b111 asynchronously. After release, slot 0 shows an=3'b110, seg=7'h40 ("0"). frame_done pulses every 12 cycles.
2. bcd=12'h255, bcd_valid pulse, blank_lz=0 -> from the next frame_done onward: an=110/seg=7'h12, then an=101/seg=7'h12, then an=011/seg=7'h24. Each slot lasts 4 clocks and the sequence repeats.
3. bcd=12'h004 committed, blank_lz=1 -> ones slot an=110/seg=7'h19. Tens and hundreds slots have an=111, seg=7'h7F. With blank_lz=0, those slots show 7'h40.
4. Display at 12'h255, then bcd=12'h196 strobed during the tens slot -> the tens and hundreds slots of the current frame still show 5 and 2. After frame_done they show 6 (7'h02), 9 (7'h10) and 1 (7'h79).
5. bcd=12'h0A0 -> tens slot seg=7'h3F (dash). bcd_valid coincident with the frame boundary -> the new value appears in the immediately following frame.
6. rst_n pulsed low mid-slot while displaying 12'h255 -> outputs inactive the same cycle. After release, the display shows 0 and pending is cleared (no stale 255 commit).
